key_conditioner: RTL

- Sits between the board push-buttons (KEY[3:0], active-low, bouncy, asynchronous) and the game entity logic.
- Per key: synchronises, debounces and tracks state; emits a clean level, one-cycle press/release pulses and optional auto-repeat pulses for held keys.
- The entity logic consumes keysout for continuous ship movement and key_press for discrete actions such as firing.

---
 rtl/key_conditioner_pkg.sv | 30 +++
 rtl/key_channel.sv | 189 ++++++++++++++++++
 rtl/key_conditioner.sv | 39 +++
 3 files changed

// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg: shared types, default timing and sizing helpers for
// the push-button conditioner. Default timing constants are in 50 MHz cycles.
package key_conditioner_pkg;

  // Per-key debounce state. The two stable states are RELEASED/PRESSED; the
  // DEB_* states hold while a level change is being qualified.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } key_state_t;

  // Default configuration for the DE-board build.
  localparam int DEF_NUM_KEYS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
  localparam int DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;   // 100 ms

  // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Larger of two integers, used to size a counter shared by two intervals.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one push-button channel. Two-flop synchroniser, four-state
// debounce FSM with a shared qualification counter, registered level and
// press/release pulses, and an optional auto-repeat generator.
// Optional feature macro: KEY_CONDITIONER_AUTOREPEAT_EN (adds the repeat
// counter; without it repeat_pulse is tied low).
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,          // raw button, active-low, asynchronous
  output logic level,          // debounced level, 1 = held
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int                 DEB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Refuse configurations the counter scheme cannot express.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_channel: DEBOUNCE_CYCLES must be >= 2 and repeat intervals >= 1");
  end

  logic             sync_q1;
  logic             sync_q2;      // synchronised key, 0 = pressed
  key_state_t       state_q;
  key_state_t       state_d;
  logic [DEB_W-1:0] cnt_q;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             level_d;
  logic             press_d;
  logic             release_d;
  logic             level_q;
  logic             press_q;
  logic             release_q;

  // Bring the asynchronous button into the clock domain; idle value is released.
  // NOTE: every clocked process uses non-blocking (<=) so all flops sample
  // pre-edge values, exactly like the hardware; blocking here would chain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a change is accepted only after the synchronised input
  // has stayed at the new level through the whole qualification window.
  // NOTE: every variable gets a default at the top of a combinational block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (!sync_q2) begin
          state_d = DEB_PRESS;
          cnt_clr = 1'b1;
        end
      end
      DEB_PRESS: begin
        if (sync_q2) begin
          state_d = RELEASED;           // glitch, no pulse
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      PRESSED: begin
        if (sync_q2) begin
          state_d = DEB_RELEASE;
          cnt_clr = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (!sync_q2) begin
          state_d = PRESSED;            // bounce, still held, no new press
        end else if (cnt_q == DEB_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // Output decode from the transition being taken this cycle, so the level
  // and its matching pulse appear on the same edge.
  always_comb begin
    press_d   = (state_q == DEB_PRESS)   && (state_d == PRESSED);
    release_d = (state_q == DEB_RELEASE) && (state_d == RELEASED);
    level_d   = (state_d == PRESSED)     || (state_d == DEB_RELEASE);
  end

  // Qualification counter shared by both debounce states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + DEB_W'(1);
    end
  end

  // Registered outputs: glitch-free level and single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic             hold_tick;     // a cycle spent steadily in PRESSED
  logic             rpt_hit;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic             rpt_armed_q;   // first (long) interval already elapsed
  logic             rpt_q;

  // Repeat timing: long delay before the first repeat, short period after.
  always_comb begin
    hold_tick = (state_q == PRESSED) && !sync_q2;
    rpt_hit   = hold_tick &&
                (rpt_armed_q ? (rpt_cnt_q == RPT_NEXT) : (rpt_cnt_q == RPT_FIRST));
  end

  // Repeat counter: cleared by a new press or release, frozen while a
  // release is being qualified, advancing only on steady hold cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      rpt_q <= rpt_hit;
      if (press_d || (state_d == RELEASED)) begin
        rpt_cnt_q   <= '0;
        rpt_armed_q <= 1'b0;
      end else if (rpt_hit) begin
        rpt_cnt_q   <= '0;
        rpt_armed_q <= 1'b1;
      end else if (hold_tick) begin
        rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  assign repeat_pulse = rpt_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: conditions the active-low board push-buttons for the game
// logic. One key_channel per button; outputs are concatenated per bit.
// Optional feature macro: KEY_CONDITIONER_AUTOREPEAT_EN (auto-repeat pulses
// on key_repeat; without it key_repeat is constant 0).
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                CLOCK_50,
  input  logic                reset,        // asynchronous, active-low
  input  logic [NUM_KEYS-1:0] keys,         // raw, 0 = pressed
  output logic [NUM_KEYS-1:0] keysout,      // debounced, 1 = held
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  // Fully independent channels, one per button.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .clk           (CLOCK_50),
      .rst_n         (reset),
      .key_n         (keys[i]),
      .level         (keysout[i]),
      .press_pulse   (key_press[i]),
      .release_pulse (key_release[i]),
      .repeat_pulse  (key_repeat[i])
    );
  end

endmodule
